// File: rtl/ysyx_25040101_pkg.sv
// Shared constants and types for the nebula-core instruction fetch path.
package ysyx_25040101_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE,
        IFU_REQ,
        IFU_WAIT,
        IFU_HOLD
    } ifu_state_e;

    typedef enum logic [2:0] {
        PC_KEEP,
        PC_RESET,
        PC_INC,
        PC_REDIRECT,
        PC_PENDING
    } pc_sel_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ysyx_25040101_ifu_if.sv
// Instruction-memory port of the IFU: a request channel and a response channel,
// each with its own valid/ready handshake.
interface ysyx_25040101_ifu_if ();
    import ysyx_25040101_pkg::*;

    logic            req_valid_o;
    logic            req_ready_i;
    logic [XLEN-1:0] req_addr_o;
    logic            rsp_valid_i;
    logic            rsp_ready_o;
    logic [XLEN-1:0] rsp_data_i;
    logic            rsp_err_i;

    modport master (
        output req_valid_o, req_addr_o, rsp_ready_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, rsp_ready_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i
    );

endinterface

// File: rtl/ysyx_25040101_ifu_pc.sv
// PC datapath of the IFU: current PC, a pending redirect target and the kill
// flag that marks the in-flight fetch as stale.
module ysyx_25040101_ifu_pc
    import ysyx_25040101_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_e         sel_i,
    input  logic            pend_set_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            kill_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic            kill_q, kill_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        kill_d    = kill_q;
        if (pend_set_i) begin
            next_pc_d = word_align(redirect_pc_i);
            kill_d    = 1'b1;
        end
        case (sel_i)
            PC_RESET: begin
                pc_d   = word_align(RESET_PC);
                kill_d = 1'b0;
            end
            PC_INC:      pc_d = pc_q + XLEN'(4);
            PC_REDIRECT: begin
                pc_d   = word_align(redirect_pc_i);
                kill_d = 1'b0;
            end
            PC_PENDING: begin
                pc_d   = next_pc_q;
                kill_d = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= word_align(RESET_PC);
            next_pc_q <= word_align(RESET_PC);
            kill_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            kill_q    <= kill_d;
        end
    end

    assign pc_o   = pc_q;
    assign kill_o = kill_q;

endmodule

// File: rtl/ysyx_25040101_ifu.sv
// Instruction fetch unit: issues one aligned fetch at a time, buffers the word
// for decode and follows redirects from execute, including mid-fetch ones.
module ysyx_25040101_ifu
    import ysyx_25040101_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_25040101_ifu_if.master mem,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [XLEN-1:0]     inst_o,
    output logic [XLEN-1:0]     pc_o,
    output logic                fault_o
);

    ifu_state_e      state_q, state_d;
    pc_sel_e         pc_sel;
    logic            pend_set;
    logic            buf_load;
    logic            kill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            fault_q, fault_d;

    ysyx_25040101_ifu_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_i        (pc_sel),
        .pend_set_i   (pend_set),
        .redirect_pc_i(redirect_pc_i),
        .pc_o         (pc),
        .kill_o       (kill)
    );

    always_comb begin
        state_d  = state_q;
        pc_sel   = PC_KEEP;
        pend_set = 1'b0;
        buf_load = 1'b0;
        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_REQ;
                pc_sel  = PC_RESET;
            end
            IFU_REQ: begin
                pend_set = redirect_valid_i;
                if (mem.req_ready_i) state_d = IFU_WAIT;
            end
            IFU_WAIT: begin
                if (mem.rsp_valid_i) begin
                    // A redirect arriving with the data overrides any older pending target.
                    state_d = IFU_REQ;
                    if (redirect_valid_i)  pc_sel = PC_REDIRECT;
                    else if (kill)         pc_sel = PC_PENDING;
                    else begin
                        state_d  = IFU_HOLD;
                        buf_load = 1'b1;
                    end
                end else begin
                    pend_set = redirect_valid_i;
                end
            end
            IFU_HOLD: begin
                if (redirect_valid_i) begin
                    state_d = IFU_REQ;
                    pc_sel  = PC_REDIRECT;
                end else if (inst_ready_i) begin
                    state_d = IFU_REQ;
                    pc_sel  = PC_INC;
                end
            end
            default: ;
        endcase
    end

    assign inst_d  = buf_load ? (mem.rsp_err_i ? INST_NOP : mem.rsp_data_i) : inst_q;
    assign fault_d = buf_load ? mem.rsp_err_i : fault_q;

    // NOTE: the instruction buffer is a single register, reset to NOP so decode never sees junk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IFU_IDLE;
            inst_q  <= INST_NOP;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    assign mem.req_valid_o = (state_q == IFU_REQ);
    assign mem.rsp_ready_o = (state_q == IFU_WAIT);
    assign mem.req_addr_o  = pc;
    assign inst_valid_o    = (state_q == IFU_HOLD);
    assign inst_o          = inst_q;
    assign pc_o            = pc;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Bench for ysyx_25040101_ifu: directed scenarios followed by randomized traffic,
// checked against an architectural next-PC model and a memory model.
module tb_ysyx_25040101_ifu;
    import ysyx_25040101_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;

    ysyx_25040101_ifu_if mem_bus ();

    ysyx_25040101_ifu #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem             (mem_bus),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .inst_valid_o    (inst_valid),
        .inst_ready_i    (inst_ready),
        .inst_o          (inst),
        .pc_o            (pc),
        .fault_o         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total   = 0;
    int passed  = 0;
    int n_cyc   = 0;
    int n_deliv = 0;

    // memory model
    bit          rand_mode = 0;
    bit          err_en    = 0;
    bit          spur_once = 0;
    bit          m_busy    = 0;
    bit          m_err     = 0;
    bit          s_err     = 0;
    int          m_delay   = 0;
    int          m_cnt     = 0;
    logic [31:0] err_addr  = '0;
    logic [31:0] m_addr    = '0;
    logic [31:0] s_addr    = '0;
    logic [31:0] req_log[$];
    int          req_cyc[$];

    // architectural model
    logic [31:0] exp_pc    = RST_PC;
    bit          hold_prev = 0;
    bit          req_prev  = 0;
    logic [31:0] h_pc, h_inst, r_addr;
    logic        h_fault;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] first_req();
        if (req_log.size() == 0) return 32'hxxxx_xxxx;
        return req_log[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic mem_model();
        mem_bus.rsp_valid_i = 1'b0;
        mem_bus.rsp_err_i   = 1'b0;
        mem_bus.rsp_data_i  = $urandom();
        mem_bus.req_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!rst_n) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                mem_bus.rsp_valid_i = 1'b1;
                mem_bus.rsp_data_i  = word_of(m_addr);
                mem_bus.rsp_err_i   = m_err;
                if (mem_bus.rsp_ready_o) begin
                    m_busy = 0;
                    s_addr = m_addr;
                    s_err  = m_err;
                end
            end else begin
                m_cnt--;
            end
        end else begin
            if (spur_once || (rand_mode && $urandom_range(0, 9) == 0)) begin
                mem_bus.rsp_valid_i = 1'b1;
                mem_bus.rsp_err_i   = 1'($urandom_range(0, 1));
            end
            spur_once = 0;
            if (mem_bus.req_valid_o && mem_bus.req_ready_i) begin
                m_busy = 1;
                m_addr = mem_bus.req_addr_o;
                m_cnt  = rand_mode ? int'($urandom_range(0, 3)) : m_delay;
                m_err  = rand_mode ? ($urandom_range(0, 7) == 0) : (err_en && m_addr == err_addr);
                req_log.push_back(m_addr);
                req_cyc.push_back(n_cyc);
            end
        end
    endtask

    task automatic ref_model();
        if (hold_prev) begin
            check("hold_valid", 32'(inst_valid), 32'd1);
            check("hold_pc", pc, h_pc);
            check("hold_inst", inst, h_inst);
            check("hold_fault", 32'(fault), 32'(h_fault));
        end
        if (req_prev) begin
            check("req_hold_valid", 32'(mem_bus.req_valid_o), 32'd1);
            check("req_hold_addr", mem_bus.req_addr_o, r_addr);
        end
        if (!rst_n) begin
            exp_pc    = RST_PC;
            hold_prev = 0;
            req_prev  = 0;
        end else begin
            if (inst_valid && inst_ready && !redirect_valid) begin
                check("deliv_pc", pc, exp_pc);
                check("deliv_src", pc, s_addr);
                check("deliv_inst", inst, s_err ? INST_NOP : word_of(s_addr));
                check("deliv_fault", 32'(fault), 32'(s_err));
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
            hold_prev = inst_valid && !inst_ready && !redirect_valid;
            h_pc      = pc;
            h_inst    = inst;
            h_fault   = fault;
            req_prev  = mem_bus.req_valid_o && !mem_bus.req_ready_i;
            r_addr    = mem_bus.req_addr_o;
        end
    endtask

    task automatic cycle();
        mem_model();
        ref_model();
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p, w;
        int          d0;
        bit          seen;

        rst_n               = 1'b0;
        inst_ready          = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        mem_bus.req_ready_i = 1'b0;
        mem_bus.rsp_valid_i = 1'b0;
        mem_bus.rsp_data_i  = '0;
        mem_bus.rsp_err_i   = 1'b0;
        @(negedge clk);

        // reset state and first request
        cycle();
        cycle();
        check("rst_req_valid", 32'(mem_bus.req_valid_o), 32'd0);
        check("rst_rsp_ready", 32'(mem_bus.rsp_ready_o), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_addr", mem_bus.req_addr_o, RST_PC);
        check("rst_pc", pc, RST_PC);
        check("rst_inst", inst, INST_NOP);
        check("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("first_req_valid", 32'(mem_bus.req_valid_o), 32'd1);

        // zero-wait streaming: three sequential fetches, 3 cycles apart
        inst_ready = 1'b1;
        req_log.delete();
        req_cyc.delete();
        for (int i = 0; i < 30 && req_log.size() < 3; i++) cycle();
        check("t1_req_count", 32'(req_log.size()), 32'd3);
        if (req_log.size() == 3) begin
            check("t1_addr0", req_log[0], 32'h8000_0000);
            check("t1_addr1", req_log[1], 32'h8000_0004);
            check("t1_addr2", req_log[2], 32'h8000_0008);
            check("t1_gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
            check("t1_gap12", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
        end

        // decode stall in HOLD
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        check("t2_hold_reached", 32'(inst_valid), 32'd1);
        p = pc;
        w = inst;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t2_no_req", 32'(mem_bus.req_valid_o), 32'd0);
            check("t2_pc_stable", pc, p);
            check("t2_inst_stable", inst, w);
        end
        req_log.delete();
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && req_log.size() == 0; i++) cycle();
        check("t2_next_addr", first_req(), p + 32'd4);

        // redirect during WAIT with a slow response
        m_delay = 3;
        for (int i = 0; i < 20 && !mem_bus.rsp_ready_o; i++) cycle();
        check("t3_wait_reached", 32'(mem_bus.rsp_ready_o), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        cycle();
        redirect_valid = 1'b0;
        req_log.delete();
        seen = 0;
        for (int i = 0; i < 20 && req_log.size() == 0; i++) begin
            cycle();
            if (inst_valid) seen = 1;
        end
        check("t3_no_inst", 32'(seen), 32'd0);
        check("t3_addr", first_req(), 32'h8000_0100);
        m_delay    = 0;
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        check("t3_pc", pc, 32'h8000_0100);

        // redirect in HOLD coinciding with a decode handshake
        d0             = n_deliv;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0202;
        cycle();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        check("t4_not_consumed", 32'(n_deliv), 32'(d0));
        check("t4_inst_valid", 32'(inst_valid), 32'd0);
        check("t4_req_valid", 32'(mem_bus.req_valid_o), 32'd1);
        check("t4_req_addr", mem_bus.req_addr_o, 32'h8000_0200);
        check("t4_pc", pc, 32'h8000_0200);

        // access fault on 8000_0004, cleared by the following fetch
        err_en   = 1;
        err_addr = 32'h8000_0004;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0004;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_inst_nop", inst, INST_NOP);
        check("t5_pc", pc, 32'h8000_0004);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        check("t5_fault_clear", 32'(fault), 32'd0);
        check("t5_next_pc", pc, 32'h8000_0008);
        check("t5_next_inst", inst, word_of(32'h8000_0008));
        err_en = 0;

        // reset during WAIT, then a stale response
        inst_ready = 1'b1;
        m_delay    = 3;
        for (int i = 0; i < 20 && !mem_bus.rsp_ready_o; i++) cycle();
        check("t6_wait_reached", 32'(mem_bus.rsp_ready_o), 32'd1);
        rst_n = 1'b0;
        cycle();
        check("t6_idle_req", 32'(mem_bus.req_valid_o), 32'd0);
        check("t6_idle_rsp", 32'(mem_bus.rsp_ready_o), 32'd0);
        check("t6_idle_inst", 32'(inst_valid), 32'd0);
        check("t6_idle_addr", mem_bus.req_addr_o, RST_PC);
        check("t6_idle_pc", pc, RST_PC);
        rst_n     = 1'b1;
        spur_once = 1;
        req_log.delete();
        cycle();
        check("t6_req_valid", 32'(mem_bus.req_valid_o), 32'd1);
        check("t6_rsp_ignored", 32'(mem_bus.rsp_ready_o), 32'd0);
        check("t6_req_addr", mem_bus.req_addr_o, RST_PC);
        spur_once = 1;
        cycle();
        check("t6_wait", 32'(mem_bus.rsp_ready_o), 32'd1);
        check("t6_no_inst", 32'(inst_valid), 32'd0);
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) cycle();
        check("t6_first_req", first_req(), RST_PC);
        check("t6_pc", pc, RST_PC);
        check("t6_inst", inst, word_of(RST_PC));
        check("t6_fault", 32'(fault), 32'd0);

        // randomized traffic against the architectural model
        rand_mode = 1;
        d0        = n_deliv;
        for (int i = 0; i < 800; i++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = (mem_bus.req_valid_o || mem_bus.rsp_ready_o || inst_valid)
                             && ($urandom_range(0, 99) < 8);
            redirect_pc    = 32'h8000_0000 | 32'($urandom_range(0, 4095));
            cycle();
        end
        redirect_valid = 1'b0;
        check("rand_progress", 32'(n_deliv - d0 >= 20), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
